// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - Morse key decoder: synchroniser, debounce, unit timing, ASCII decode.
// Optional MORSE_DEC_PUNCT_EN adds . , ? / = to the decode table.
module morse_decoder #(
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int DEB_CYCLES  = 250_000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iKEY,
  output logic       oTONE,
  output logic [7:0] oCHAR,
  output logic       oVALID,
  output logic       oERR
);

  localparam int PW = $clog2(UNIT_CYCLES + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic          rSync1;
  logic          rSync2;
  logic [DW-1:0] rDebCnt;
  logic [PW-1:0] rPRE;
  logic [2:0]    rDUR;
  logic [5:0]    rCODE;
  logic [2:0]    rLEN;
  logic          rOVF;
  logic          rWORD;

  logic       differ;
  logic       flip;
  logic       tick;
  logic       letterGap;
  logic       wordGap;
  logic [8:0] lookup;

  // Returns {hit, ascii}; first element keyed sits in the highest used code bit.
  function automatic logic [8:0] decode(input logic [2:0] len, input logic [5:0] code);
    logic [8:0] r;
    r = 9'h000;
    case ({len, code})
      9'b010_000001: r = {1'b1, 8'h41};
      9'b100_001000: r = {1'b1, 8'h42};
      9'b100_001010: r = {1'b1, 8'h43};
      9'b011_000100: r = {1'b1, 8'h44};
      9'b001_000000: r = {1'b1, 8'h45};
      9'b100_000010: r = {1'b1, 8'h46};
      9'b011_000110: r = {1'b1, 8'h47};
      9'b100_000000: r = {1'b1, 8'h48};
      9'b010_000000: r = {1'b1, 8'h49};
      9'b100_000111: r = {1'b1, 8'h4A};
      9'b011_000101: r = {1'b1, 8'h4B};
      9'b100_000100: r = {1'b1, 8'h4C};
      9'b010_000011: r = {1'b1, 8'h4D};
      9'b010_000010: r = {1'b1, 8'h4E};
      9'b011_000111: r = {1'b1, 8'h4F};
      9'b100_000110: r = {1'b1, 8'h50};
      9'b100_001101: r = {1'b1, 8'h51};
      9'b011_000010: r = {1'b1, 8'h52};
      9'b011_000000: r = {1'b1, 8'h53};
      9'b001_000001: r = {1'b1, 8'h54};
      9'b011_000001: r = {1'b1, 8'h55};
      9'b100_000001: r = {1'b1, 8'h56};
      9'b011_000011: r = {1'b1, 8'h57};
      9'b100_001001: r = {1'b1, 8'h58};
      9'b100_001011: r = {1'b1, 8'h59};
      9'b100_001100: r = {1'b1, 8'h5A};
      9'b101_011111: r = {1'b1, 8'h30};
      9'b101_001111: r = {1'b1, 8'h31};
      9'b101_000111: r = {1'b1, 8'h32};
      9'b101_000011: r = {1'b1, 8'h33};
      9'b101_000001: r = {1'b1, 8'h34};
      9'b101_000000: r = {1'b1, 8'h35};
      9'b101_010000: r = {1'b1, 8'h36};
      9'b101_011000: r = {1'b1, 8'h37};
      9'b101_011100: r = {1'b1, 8'h38};
      9'b101_011110: r = {1'b1, 8'h39};
`ifdef MORSE_DEC_PUNCT_EN
      9'b110_010101: r = {1'b1, 8'h2E};
      9'b110_110011: r = {1'b1, 8'h2C};
      9'b110_001100: r = {1'b1, 8'h3F};
      9'b101_010010: r = {1'b1, 8'h2F};
      9'b101_010001: r = {1'b1, 8'h3D};
`endif
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  assign differ    = (rSync2 != oTONE);
  assign flip      = differ && (rDebCnt == DW'(DEB_CYCLES - 1));
  assign tick      = (rPRE == PW'(UNIT_CYCLES - 1));
  // Gap checks look at the cycle just after the tick that moved rDUR, so each fires once.
  assign letterGap = !oTONE && (rDUR == 3'd2) && (rPRE == '0) && (rLEN != 3'd0);
  assign wordGap   = !oTONE && (rDUR == 3'd5) && (rPRE == '0) && rWORD;
  assign lookup    = decode(rLEN, rCODE);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rSync1  <= 1'b0;
      rSync2  <= 1'b0;
      rDebCnt <= '0;
      oTONE   <= 1'b0;
      rPRE    <= '0;
      rDUR    <= 3'd0;
      rCODE   <= 6'd0;
      rLEN    <= 3'd0;
      rOVF    <= 1'b0;
      rWORD   <= 1'b0;
      oCHAR   <= 8'h00;
      oVALID  <= 1'b0;
      oERR    <= 1'b0;
    end else begin
      rSync1 <= iKEY;
      rSync2 <= rSync1;
      oVALID <= 1'b0;
      oERR   <= 1'b0;

      if (!differ || flip) rDebCnt <= '0;
      else                 rDebCnt <= rDebCnt + 1'b1;

      if (flip) begin
        oTONE <= rSync2;
        rPRE  <= '0;
        rDUR  <= 3'd0;
        if (oTONE) begin
          if (rLEN == 3'd6) begin
            rOVF <= 1'b1;
          end else begin
            rCODE <= {rCODE[4:0], (rDUR >= 3'd2)};
            rLEN  <= rLEN + 1'b1;
          end
        end
      end else begin
        rPRE <= tick ? '0 : rPRE + 1'b1;
        if (tick && rDUR != 3'd7) rDUR <= rDUR + 1'b1;
      end

      if (letterGap) begin
        if (rOVF || !lookup[8]) begin
          oERR <= 1'b1;
        end else begin
          oCHAR  <= lookup[7:0];
          oVALID <= 1'b1;
          rWORD  <= 1'b1;
        end
        rCODE <= 6'd0;
        rLEN  <= 3'd0;
        rOVF  <= 1'b0;
      end else if (wordGap) begin
        oCHAR  <= 8'h20;
        oVALID <= 1'b1;
        rWORD  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// tb/tb_morse_decoder.sv - Directed bench for morse_decoder (UNIT 100, DEB 4).
module tb_morse_decoder;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic       iKEY;
  logic       oTONE;
  logic [7:0] oCHAR;
  logic       oVALID;
  logic       oERR;

  morse_decoder #(.UNIT_CYCLES(100), .DEB_CYCLES(4)) dut (
    .iCLK(iCLK), .iRST(iRST), .iKEY(iKEY),
    .oTONE(oTONE), .oCHAR(oCHAR), .oVALID(oVALID), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

`ifdef MORSE_DEC_PUNCT_EN
  localparam bit PUNCT = 1'b1;
`else
  localparam bit PUNCT = 1'b0;
`endif

  typedef struct {
    logic       err;
    logic [7:0] ch;
    int         dly;
  } ev_t;

  typedef struct {
    logic [2:0] len;
    logic [6:0] code;
    logic       err;
    logic [7:0] ch;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];
  ev_t  evQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lastFall = 0;
  int   toneChanges = 0;
  int   overlap = 0;
  logic prevTone = 1'b0;

  always @(posedge iCLK) cyc <= cyc + 1;

  // Strobe recorder: each strobe is stamped with its distance from the last falling tone edge.
  always @(negedge iCLK) begin
    if (prevTone && !oTONE) lastFall = cyc;
    if (oTONE !== prevTone) toneChanges++;
    prevTone = oTONE;
    if (oVALID && oERR) overlap++;
    if (oVALID || oERR) evQ.push_back('{err: oERR, ch: oCHAR, dly: cyc - lastFall});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic keyElem(input logic dash);
    iKEY = 1'b1;
    idle(dash ? 300 : 100);
    iKEY = 1'b0;
    idle(100);
  endtask

  task automatic keyChar(input logic [2:0] len, input logic [6:0] code);
    for (int i = int'(len) - 1; i >= 0; i--) keyElem(code[i]);
  endtask

  task automatic checkLetter(input string tag, input int idx, input logic [7:0] ch);
    if (evQ.size() > idx) begin
      check({tag, "_kind"}, 32'(evQ[idx].err), 32'd0);
      check({tag, "_char"}, 32'(evQ[idx].ch), 32'(ch));
      check({tag, "_dly"}, evQ[idx].dly, (ch == 8'h20) ? 32'd501 : 32'd201);
    end
  endtask

  initial begin
    vecs[0]  = '{3'd2, 7'b0000001, 1'b0, 8'h41};
    vecs[1]  = '{3'd1, 7'b0000001, 1'b0, 8'h54};
    vecs[2]  = '{3'd1, 7'b0000000, 1'b0, 8'h45};
    vecs[3]  = '{3'd5, 7'b0000000, 1'b0, 8'h35};
    vecs[4]  = '{3'd5, 7'b0011111, 1'b0, 8'h30};
    vecs[5]  = '{3'd4, 7'b0001101, 1'b0, 8'h51};
    vecs[6]  = '{3'd4, 7'b0001100, 1'b0, 8'h5A};
    vecs[7]  = '{3'd5, 7'b0011110, 1'b0, 8'h39};
    vecs[8]  = '{3'd7, 7'b0000000, 1'b1, 8'h00};
    vecs[9]  = '{3'd1, 7'b0000001, 1'b0, 8'h54};
    vecs[10] = '{3'd4, 7'b0000011, 1'b1, 8'h00};
    vecs[11] = '{3'd6, 7'b0001100, !PUNCT, 8'h3F};
    vecs[12] = '{3'd6, 7'b0010101, !PUNCT, 8'h2E};
    vecs[13] = '{3'd5, 7'b0010001, !PUNCT, 8'h3D};
    vecs[14] = '{3'd4, 7'b0001000, 1'b0, 8'h42};
    vecs[15] = '{3'd4, 7'b0001011, 1'b0, 8'h59};
    vecs[16] = '{3'd4, 7'b0001001, 1'b0, 8'h58};

    iRST = 1'b1;
    iKEY = 1'b0;
    idle(5);
    iRST = 1'b0;
    idle(1);
    check("rst_tone", 32'(oTONE), 32'd0);
    check("rst_char", 32'(oCHAR), 32'd0);
    check("rst_valid", 32'(oVALID), 32'd0);
    check("rst_err", 32'(oERR), 32'd0);
    evQ.delete();
    idle(2000);
    check("idle_strobes", evQ.size(), 32'd0);
    check("idle_tone", toneChanges, 32'd0);

    // SOS with 300-cycle letter gaps, then 800 cycles idle.
    evQ.delete();
    keyChar(3'd3, 7'b0000000); idle(200);
    keyChar(3'd3, 7'b0000111); idle(200);
    keyChar(3'd3, 7'b0000000); idle(700);
    check("sos_count", evQ.size(), 32'd4);
    checkLetter("sos_s1", 0, 8'h53);
    checkLetter("sos_o", 1, 8'h4F);
    checkLetter("sos_s2", 2, 8'h53);
    checkLetter("sos_sp", 3, 8'h20);

    for (int v = 0; v < NV; v++) begin
      evQ.delete();
      keyChar(vecs[v].len, vecs[v].code);
      idle(500);
      if (vecs[v].err) begin
        check($sformatf("vec%0d_count", v), evQ.size(), 32'd1);
        if (evQ.size() > 0) begin
          check($sformatf("vec%0d_err", v), 32'(evQ[0].err), 32'd1);
          check($sformatf("vec%0d_errdly", v), evQ[0].dly, 32'd201);
        end
      end else begin
        check($sformatf("vec%0d_count", v), evQ.size(), 32'd2);
        checkLetter($sformatf("vec%0d", v), 0, vecs[v].ch);
        checkLetter($sformatf("vec%0d_sp", v), 1, 8'h20);
      end
    end

    // Short glitches must never reach oTONE.
    evQ.delete();
    begin
      int base;
      base = toneChanges;
      repeat (10) begin
        iKEY = 1'b1; idle(3);
        iKEY = 1'b0; idle(47);
      end
      idle(300);
      check("glitch_tone", toneChanges, base);
      check("glitch_strobes", evQ.size(), 32'd0);
    end

    // "E" with bounce on both edges.
    evQ.delete();
    iKEY = 1'b1; idle(2);
    iKEY = 1'b0; idle(2);
    iKEY = 1'b1; idle(100);
    iKEY = 1'b0; idle(2);
    iKEY = 1'b1; idle(2);
    iKEY = 1'b0; idle(600);
    check("bounce_count", evQ.size(), 32'd2);
    checkLetter("bounce_e", 0, 8'h45);

    // Long key-down saturates and decodes as a dash.
    evQ.delete();
    iKEY = 1'b1; idle(1500);
    iKEY = 1'b0; idle(600);
    check("long_count", evQ.size(), 32'd2);
    checkLetter("long_t", 0, 8'h54);

    // Reset in the element gap after ".-" discards the pending sequence.
    evQ.delete();
    keyElem(1'b0);
    keyElem(1'b1);
    iRST = 1'b1; idle(1);
    iRST = 1'b0;
    check("midrst_tone", 32'(oTONE), 32'd0);
    keyChar(3'd1, 7'b0000001);
    idle(500);
    check("midrst_count", evQ.size(), 32'd2);
    checkLetter("midrst_t", 0, 8'h54);
    checkLetter("midrst_sp", 1, 8'h20);

    idle(700);
    check("hold_char", 32'(oCHAR), 32'h20);
    check("no_overlap", overlap, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
